// File: rtl/burst_index_gen.sv
// -----------------------------------------------------------------------------
// burst_index_gen
//
// Burst source: accepts one start request carrying a length, a base address and
// a stride, then emits cfg_len+1 beats under a valid/ready handshake. Each beat
// carries its index, the address base + idx*stride (mod 2^ADDR_WIDTH) and a last
// flag on the final beat. A one-cycle done pulse follows the final transfer.
//
// Optional feature (compile-time macro BURST_GEN_ABORT_EN):
//   adds input abort and output aborted. Abort in RUN ends the burst at once,
//   pulses aborted for one cycle and suppresses done. Ignored in IDLE.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_vld   burst request
//   start_rdy   request accepted when start_vld && start_rdy (high in IDLE)
//   cfg_len     beats minus one, sampled on the start handshake
//   cfg_base    address of beat 0, sampled on the start handshake
//   cfg_stride  address increment per beat, sampled on the start handshake
//   out_vld     beat valid
//   out_rdy     sink ready
//   out_idx     beat index 0..len
//   out_addr    beat address
//   out_last    high on the final beat
//   busy        high while a burst is in progress
//   done        one-cycle pulse after the final beat transfers
//   abort       (BURST_GEN_ABORT_EN only) terminate the running burst
//   aborted     (BURST_GEN_ABORT_EN only) one-cycle pulse after an abort
// -----------------------------------------------------------------------------
module burst_index_gen #(
  parameter int CNT_WIDTH  = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_vld,
  output logic                  start_rdy,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [CNT_WIDTH-1:0]  out_idx,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef BURST_GEN_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  idx_next;
  logic                  beat_xfer;

  // Requests are only taken between bursts; a request raised during RUN
  // simply waits for the next IDLE cycle.
  assign start_rdy = (state == IDLE);
  assign beat_xfer = out_vld && out_rdy;
  assign idx_next  = out_idx + CNT_WIDTH'(1);

  // NOTE: every register here, including the captured config, is reset and
  // updated with non-blocking assignments so all of them see the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      stride_q <= '0;
      out_vld  <= 1'b0;
      out_idx  <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef BURST_GEN_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      // Pulses default low and are raised only on the cycle they apply.
      done <= 1'b0;
`ifdef BURST_GEN_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_vld) begin
            len_q    <= cfg_len;
            stride_q <= cfg_stride;
            out_idx  <= '0;
            out_addr <= cfg_base;
            out_last <= (cfg_len == '0);
            out_vld  <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
`ifdef BURST_GEN_ABORT_EN
          // Abort overrides any same-cycle transfer, including the last one;
          // index and address keep the values of the beat on the bus.
          if (abort) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            state    <= IDLE;
          end else
`endif
          if (beat_xfer) begin
            if (!out_last) begin
              out_idx  <= idx_next;
              out_addr <= out_addr + stride_q;  // wraps silently
              out_last <= (idx_next == len_q);
            end else begin
              // Index and address keep the final beat's values until the
              // next start.
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_index_gen.sv
// -----------------------------------------------------------------------------
// tb_burst_index_gen
//
// Drives burst_index_gen with directed and random stimulus. The reference
// model expands every accepted request into its full list of beats
// (idx, base + idx*stride, last) up front and pops one per transfer; all
// outputs are predicted from that list.
// -----------------------------------------------------------------------------
module tb_burst_index_gen;

  localparam int CW = 4;
  localparam int AW = 16;
`ifdef BURST_GEN_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start_vld;
  logic          start_rdy;
  logic [CW-1:0] cfg_len;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_stride;
  logic          out_vld;
  logic          out_rdy;
  logic [CW-1:0] out_idx;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          abort;
  logic          aborted;

  burst_index_gen #(.CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_vld  (start_vld),
    .start_rdy  (start_rdy),
    .cfg_len    (cfg_len),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_idx    (out_idx),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef BURST_GEN_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

`ifndef BURST_GEN_ABORT_EN
  assign aborted = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [CW-1:0] idx;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [CW-1:0] hold_idx;
  logic [AW-1:0] hold_addr;
  logic          exp_done;
  logic          exp_aborted;

  int vectors;
  int miscompares;
  int cyc;

  task automatic model_reset();
    exp_q.delete();
    hold_idx    = '0;
    hold_addr   = '0;
    exp_done    = 1'b0;
    exp_aborted = 1'b0;
  endtask

  // Expected outputs packed as {aborted, start_rdy, out_vld, busy, done,
  // out_last, out_idx, out_addr}.
  function automatic logic [25:0] exp_vec();
    logic          vld;
    logic [CW-1:0] i;
    logic [AW-1:0] a;
    logic          l;
    vld = (exp_q.size() != 0);
    if (vld) begin
      i = exp_q[0].idx;
      a = exp_q[0].addr;
      l = exp_q[0].last;
    end else begin
      i = hold_idx;
      a = hold_addr;
      l = 1'b0;
    end
    return {exp_aborted, !vld, vld, vld, exp_done, l, i, a};
  endfunction

  function automatic logic [25:0] obs_vec();
    return {aborted, start_rdy, out_vld, busy, done, out_last, out_idx, out_addr};
  endfunction

  // Applies one cycle of stimulus, advances the model at the rising edge and
  // returns on the following falling edge, where outputs are sampled.
  task automatic edge_cycle(input bit sv, input logic [CW-1:0] len,
                            input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input bit rdy, input bit ab);
    beat_t b;
    start_vld  = sv;
    cfg_len    = len;
    cfg_base   = base;
    cfg_stride = stride;
    out_rdy    = rdy;
    abort      = ab;
    @(posedge clk);
    exp_done    = 1'b0;
    exp_aborted = 1'b0;
    if (exp_q.size() == 0) begin
      if (sv) begin
        for (int i = 0; i <= int'(len); i++) begin
          b.idx  = CW'(i);
          b.addr = AW'(base + stride * AW'(i));
          b.last = (i == int'(len));
          exp_q.push_back(b);
        end
      end
    end else if (ABORT_EN && ab) begin
      hold_idx    = exp_q[0].idx;
      hold_addr   = exp_q[0].addr;
      exp_q.delete();
      exp_aborted = 1'b1;
    end else if (rdy) begin
      b = exp_q.pop_front();
      if (exp_q.size() == 0) begin
        hold_idx  = b.idx;
        hold_addr = b.addr;
        exp_done  = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    edge_cycle(0, '0, '0, '0, 0, 0);
    model_reset();
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_hold cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_cycle(0, CW'($urandom), AW'($urandom), AW'($urandom), 1, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic_len3();
    edge_cycle(1, 4'd3, 16'h0100, 16'h0010, 1, 0);
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic_len3 cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
      edge_cycle(0, 4'd9, 16'hDEAD, 16'h0001, 1, 0);
    end
  endtask

  task automatic test_wrap_stall();
    bit rdy_pat[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    edge_cycle(1, 4'd2, 16'hFFF8, 16'h0008, rdy_pat[0], 0);
    for (int k = 1; k < 6; k++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_stall cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
      edge_cycle(0, '0, '0, '0, rdy_pat[k], 0);
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_stall_tail cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
      edge_cycle(0, '0, '0, '0, 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    // start_vld held high with len=0: one beat, done, immediate re-accept.
    for (int k = 0; k < 7; k++) begin
      edge_cycle(1, 4'd0, 16'h0042, 16'h0005, 1, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
    end
    edge_cycle(0, '0, '0, '0, 1, 0);
    edge_cycle(0, '0, '0, '0, 1, 0);
  endtask

  task automatic test_start_while_busy();
    edge_cycle(1, 4'd15, AW'($urandom), AW'($urandom), 0, 0);
    for (int k = 0; k < 80; k++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL start_while_busy cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
      // A different request stays pending for the whole run.
      edge_cycle(1, 4'd1, 16'h1234, 16'h0100, ($urandom_range(0, 3) != 0), 0);
    end
  endtask

  task automatic test_reset_mid_burst();
    edge_cycle(1, 4'd5, 16'h0200, 16'h0004, 1, 0);
    edge_cycle(0, '0, '0, '0, 1, 0);
    edge_cycle(0, '0, '0, '0, 1, 0);
    edge_cycle(0, '0, '0, '0, 1, 0);
    // Asynchronous reset: outputs must clear without waiting for an edge.
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_mid_burst cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_cycle(0, '0, '0, '0, 1, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_no_done cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef BURST_GEN_ABORT_EN
  task automatic test_abort();
    edge_cycle(1, 4'd5, 16'h0300, 16'h0002, 1, 1);  // abort in IDLE ignored
    edge_cycle(0, '0, '0, '0, 1, 0);
    edge_cycle(0, '0, '0, '0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL abort cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
      edge_cycle(0, '0, '0, '0, 1, 1);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      edge_cycle(($urandom_range(0, 2) == 0), CW'($urandom), AW'($urandom),
                 (($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom)),
                 ($urandom_range(0, 2) != 0),
                 (ABORT_EN && ($urandom_range(0, 15) == 0)));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: dut %h model %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    start_vld   = 1'b0;
    cfg_len     = '0;
    cfg_base    = '0;
    cfg_stride  = '0;
    out_rdy     = 1'b0;
    abort       = 1'b0;
    model_reset();
    @(negedge clk);

    test_reset();
    test_basic_len3();
    test_wrap_stall();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_burst();
`ifdef BURST_GEN_ABORT_EN
    test_abort();
`endif
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
